// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_isa_pkg
// Brief    : MIPS opcode, funct and request-kind encodings shared with Control.
// Revision : 1.0
// ============================================================================
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    KIND_R       = 3'd0,
    KIND_LW      = 3'd1,
    KIND_SW      = 3'd2,
    KIND_BEQ     = 3'd3,
    KIND_ORI     = 3'd4,
    KIND_ADDIU   = 3'd5,
    KIND_J       = 3'd6,
    KIND_ILLEGAL = 3'd7
  } req_kind_e;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module   : instr_pack
// Brief    : Combinational request-kind + fields to 32-bit MIPS word encoder.
// Revision : 1.0
// ============================================================================
module instr_pack
  import cpu_isa_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req_kind_e'(kind))
      KIND_R:     word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
      KIND_LW:    word = {OP_LW,    rs, rt, imm};
      KIND_SW:    word = {OP_SW,    rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ,   rs, rt, imm};
      KIND_ORI:   word = {OP_ORI,   rs, rt, imm};
      KIND_ADDIU: word = {OP_ADDIU, rs, rt, imm};
      KIND_J:     word = {OP_J,     target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Encodes instruction requests and streams them into IMEM through a
//            registered write port with an auto-incrementing word address.
// Revision : 1.0
// ============================================================================
module instr_encoder_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_PEND  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_err;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_accept;
  logic        w_legal_accept;
  logic        w_done;

  instr_pack u_pack (
    .kind    (req_kind),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .funct   (req_funct),
    .imm     (req_imm),
    .target  (req_target),
    .word    (w_word),
    .illegal (w_illegal)
  );

  // Ready never looks at req_valid so the requester may wait on it freely.
  assign req_ready      = ~reset & ~clear & ~r_full & (~imem_we | imem_ready);
  assign w_accept       = req_valid & req_ready;
  assign w_legal_accept = w_accept & ~w_illegal;
  assign w_done         = imem_we & imem_ready;

  always_ff @(posedge clk) begin
    if (reset || clear) r_state <= ST_EMPTY;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_legal_accept) w_state_nxt = ST_PEND;
      ST_PEND:  if (w_done && !w_legal_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    imem_we = (r_state == ST_PEND);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_addr      <= c_base_addr;
      r_next_addr <= c_base_addr;
      r_wdata     <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_legal_accept) begin
        r_addr      <= r_next_addr;
        r_wdata     <= w_word;
        r_next_addr <= r_next_addr + 1'b1;
        if (r_next_addr == c_last_addr) r_full <= 1'b1;
      end
      if (w_accept && w_illegal) r_err <= 1'b1;
      if (w_done) r_count <= r_count + 1'b1;
    end
  end

  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_count;
  assign full       = r_full;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Brief    : Scoreboard bench: main instance (ADDR_W=10) plus a 4-word instance
//            for the full condition; hand-computed expected words.
// Revision : 1.0
// ============================================================================
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b1;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic        m_valid = 1'b0, m_clear = 1'b0, m_ready, m_we, m_full, m_err;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [10:0] m_count;

  logic        s_valid = 1'b0, s_clear = 1'b0, s_ready, s_we, s_full, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  exp_t m_q[$];
  exp_t s_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(m_clear), .req_valid(m_valid), .req_ready(m_ready),
    .req_kind(kind), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_funct(funct),
    .req_imm(imm), .req_target(target), .imem_we(m_we), .imem_ready(imem_ready),
    .imem_addr(m_addr), .imem_wdata(m_wdata), .word_count(m_count), .full(m_full), .err(m_err)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .reset(reset), .clear(s_clear), .req_valid(s_valid), .req_ready(s_ready),
    .req_kind(kind), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_funct(funct),
    .req_imm(imm), .req_target(target), .imem_we(s_we), .imem_ready(imem_ready),
    .imem_addr(s_addr), .imem_wdata(s_wdata), .word_count(s_count), .full(s_full), .err(s_err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitors: a write completes at the next rising edge when we & ready are both high.
  always @(negedge clk) begin
    if (!reset && !m_clear && m_we && imem_ready) begin
      if (m_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL m_unexpected_write: got addr 0x%0h data 0x%0h, expected no write", m_addr, m_wdata);
      end else begin
        exp_t e;
        e = m_q.pop_front();
        chk("m_addr", {22'b0, m_addr}, {22'b0, e.addr});
        chk("m_wdata", m_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && !s_clear && s_we && imem_ready) begin
      if (s_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL s_unexpected_write: got addr 0x%0h data 0x%0h, expected no write", s_addr, s_wdata);
      end else begin
        exp_t e;
        e = s_q.pop_front();
        chk("s_addr", {30'b0, s_addr}, {22'b0, e.addr});
        chk("s_wdata", s_wdata, e.data);
      end
    end
  end

  task automatic send(input bit sm, input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [5:0] f, input logic [15:0] im,
                      input logic [25:0] tg, input logic [31:0] exp_w, input int exp_a,
                      input int budget, output bit acc, output int waited);
    kind = k; rs = a; rt = b; rd = c; funct = f; imm = im; target = tg;
    if (sm) s_valid = 1'b1; else m_valid = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < budget) begin
      @(negedge clk);
      acc = sm ? s_ready : m_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    s_valid = 1'b0;
    m_valid = 1'b0;
    if (acc && k != 3'd7) begin
      if (sm) s_q.push_back('{exp_a[9:0], exp_w});
      else    m_q.push_back('{exp_a[9:0], exp_w});
    end
  endtask

  task automatic pulse_clear(input bit sm);
    if (sm) s_clear = 1'b1; else m_clear = 1'b1;
    @(posedge clk); #1;
    s_clear = 1'b0;
    m_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int w;
    int total;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_we", {31'b0, m_we}, 32'd0);
    chk("rst_addr", {22'b0, m_addr}, 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_count", {21'b0, m_count}, 32'd0);
    chk("rst_full", {31'b0, m_full}, 32'd0);
    chk("rst_err", {31'b0, m_err}, 32'd0);
    chk("rst_ready", {31'b0, m_ready}, 32'd1);
    @(posedge clk); #1;

    // Single lw: write presented the cycle after acceptance.
    send(0, 3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0004, 26'd0, 32'h8D090004, 0, 8, acc, w);
    chk("lw_accept_wait", w, 1);
    chk("lw_we", {31'b0, m_we}, 32'd1);
    chk("lw_addr_now", {22'b0, m_addr}, 32'd0);
    chk("lw_wdata_now", m_wdata, 32'h8D090004);
    @(posedge clk); #1;
    chk("lw_count", {21'b0, m_count}, 32'd1);

    // Back-to-back stream.
    pulse_clear(0);
    total = 0;
    send(0, 3'd0, 5'd8,  5'd9,  5'd10, 6'h20, 16'h0000, 26'd0,     32'h01095020, 0, 8, acc, w); total += w;
    send(0, 3'd2, 5'd29, 5'd31, 5'd0,  6'd0,  16'h0008, 26'd0,     32'hAFBF0008, 1, 8, acc, w); total += w;
    send(0, 3'd3, 5'd8,  5'd9,  5'd0,  6'd0,  16'hFFFE, 26'd0,     32'h1109FFFE, 2, 8, acc, w); total += w;
    send(0, 3'd4, 5'd0,  5'd8,  5'd0,  6'd0,  16'h00FF, 26'd0,     32'h340800FF, 3, 8, acc, w); total += w;
    send(0, 3'd5, 5'd0,  5'd8,  5'd0,  6'd0,  16'hFFFF, 26'd0,     32'h2408FFFF, 4, 8, acc, w); total += w;
    send(0, 3'd6, 5'd0,  5'd0,  5'd0,  6'd0,  16'h0000, 26'h10,    32'h08000010, 5, 8, acc, w); total += w;
    chk("stream_cycles", total, 6);
    @(posedge clk); #1;
    chk("stream_count", {21'b0, m_count}, 32'd6);
    chk("stream_we_idle", {31'b0, m_we}, 32'd0);

    // Stall then release with a new request accepted in the completing cycle.
    pulse_clear(0);
    imem_ready = 1'b0;
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 6'h22, 16'h0000, 26'd0, 32'h00221822, 0, 8, acc, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_we", {31'b0, m_we}, 32'd1);
      chk("stall_ready", {31'b0, m_ready}, 32'd0);
      chk("stall_addr", {22'b0, m_addr}, 32'd0);
      chk("stall_wdata", m_wdata, 32'h00221822);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    send(0, 3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0010, 26'd0, 32'h8D090010, 1, 8, acc, w);
    chk("release_accept_wait", w, 1);
    @(posedge clk); #1;
    chk("release_count", {21'b0, m_count}, 32'd2);

    // Illegal kind between two legal requests.
    pulse_clear(0);
    chk("clr_err", {31'b0, m_err}, 32'd0);
    send(0, 3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0004, 26'd0, 32'h8D090004, 0, 8, acc, w);
    send(0, 3'd7, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1234, 26'd5, 32'h0, 0, 8, acc, w);
    chk("illegal_accepted", {31'b0, acc}, 32'd1);
    chk("illegal_err", {31'b0, m_err}, 32'd1);
    send(0, 3'd2, 5'd29, 5'd31, 5'd0, 6'd0, 16'h0008, 26'd0, 32'hAFBF0008, 1, 8, acc, w);
    repeat (2) @(posedge clk); #1;
    chk("illegal_count", {21'b0, m_count}, 32'd2);
    chk("illegal_err_sticky", {31'b0, m_err}, 32'd1);

    // Clear while a write is stalled drops it.
    pulse_clear(0);
    imem_ready = 1'b0;
    send(0, 3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FF, 32'h080003FF, 0, 8, acc, w);
    @(posedge clk); #1;
    m_clear = 1'b1;
    @(posedge clk); #1;
    m_clear = 1'b0;
    m_q.delete();
    chk("drop_we", {31'b0, m_we}, 32'd0);
    chk("drop_count", {21'b0, m_count}, 32'd0);
    imem_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("drop_count_later", {21'b0, m_count}, 32'd0);

    // Full on the 4-word instance.
    for (int i = 0; i < 4; i++) begin
      send(1, 3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'(i), 26'd0, 32'h8D090000 | i, i, 4, acc, w);
      chk("fill_accepted", {31'b0, acc}, 32'd1);
    end
    chk("full_set", {31'b0, s_full}, 32'd1);
    chk("full_ready", {31'b0, s_ready}, 32'd0);
    send(1, 3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0009, 26'd0, 32'h8D090009, 0, 4, acc, w);
    chk("full_fifth_rejected", {31'b0, acc}, 32'd0);
    chk("full_count", {29'b0, s_count}, 32'd4);
    chk("full_held", {31'b0, s_full}, 32'd1);
    pulse_clear(1);
    chk("full_cleared", {31'b0, s_full}, 32'd0);
    send(1, 3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h00FF, 26'd0, 32'h340800FF, 0, 4, acc, w);
    chk("after_clear_accepted", {31'b0, acc}, 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("after_clear_count", {29'b0, s_count}, 32'd1);

    chk("m_queue_empty", m_q.size(), 32'd0);
    chk("s_queue_empty", s_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
